// File: rtl/button_conditioner.sv
// Four-channel push-button front end: two-flop synchroniser, debouncer,
// auto-repeat for dec/inc, and suppression of opposing pulses.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000,
    parameter int CNT_W           = 26
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_dec,
    input  logic btn_inc,
    input  logic btn_prev,
    input  logic btn_next,
    output logic dec,
    output logic inc,
    output logic prev,
    output logic next
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rep_state_t;

    // Channel index order: 0 = dec, 1 = inc, 2 = prev, 3 = next.
    logic [3:0]            raw;
    logic [3:0]            s1;
    logic [3:0]            s2;
    logic [3:0]            state;
    logic [3:0][CNT_W-1:0] dcnt;
    logic [3:0]            press;
    logic [3:0]            fall;
    rep_state_t            rstate [2];
    logic [1:0][CNT_W-1:0] rcnt;
    logic [1:0]            rep;
    logic [3:0]            cand;

    assign raw = {btn_next, btn_prev, btn_inc, btn_dec};

    always_comb begin
        press = '0;
        fall  = '0;
        rep   = '0;
        for (int i = 0; i < 4; i++) begin
            press[i] = s2[i] & ~state[i] & (dcnt[i] == DB_LAST);
            fall[i]  = ~s2[i] & state[i] & (dcnt[i] == DB_LAST);
        end
        // A release on the same edge as a repeat point cancels that repeat.
        for (int j = 0; j < 2; j++) begin
            rep[j] = ~fall[j] &
                     (((rstate[j] == HOLD)   && (rcnt[j] == HOLD_LAST)) ||
                      ((rstate[j] == REPEAT) && (rcnt[j] == REP_LAST)));
        end
        cand = {press[3:2], press[1:0] | rep};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1     <= '0;
            s2     <= '0;
            state  <= '0;
            dcnt   <= '0;
            rcnt   <= '0;
            rstate[0] <= IDLE;
            rstate[1] <= IDLE;
            dec    <= 1'b0;
            inc    <= 1'b0;
            prev   <= 1'b0;
            next   <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == state[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DB_LAST) begin
                    state[i] <= s2[i];
                    dcnt[i]  <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + ONE;
                end
            end
            for (int j = 0; j < 2; j++) begin
                if (fall[j]) begin
                    rstate[j] <= IDLE;
                    rcnt[j]   <= '0;
                end else begin
                    case (rstate[j])
                        IDLE: begin
                            if (press[j]) begin
                                rstate[j] <= HOLD;
                                rcnt[j]   <= '0;
                            end
                        end
                        HOLD: begin
                            if (rcnt[j] == HOLD_LAST) begin
                                rstate[j] <= REPEAT;
                                rcnt[j]   <= '0;
                            end else begin
                                rcnt[j] <= rcnt[j] + ONE;
                            end
                        end
                        REPEAT: begin
                            if (rcnt[j] == REP_LAST) rcnt[j] <= '0;
                            else                     rcnt[j] <= rcnt[j] + ONE;
                        end
                        default: begin
                            rstate[j] <= IDLE;
                            rcnt[j]   <= '0;
                        end
                    endcase
                end
            end
            // Opposing candidates on the same edge cancel each other.
            dec  <= cand[0] & ~cand[1];
            inc  <= cand[1] & ~cand[0];
            prev <= cand[2] & ~cand[3];
            next <= cand[3] & ~cand[2];
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random button
// activity, compared every cycle against a timing-level reference model.
module tb_button_conditioner;

    localparam int D = 4;
    localparam int H = 10;
    localparam int R = 3;

    logic clock;
    logic reset;
    logic btn_dec, btn_inc, btn_prev, btn_next;
    logic dec, inc, prev, next;

    int tests_run = 0;
    int tests_failed = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES(H),
        .REPEAT_CYCLES(R),
        .CNT_W(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .btn_dec(btn_dec),
        .btn_inc(btn_inc),
        .btn_prev(btn_prev),
        .btn_next(btn_next),
        .dec(dec),
        .inc(inc),
        .prev(prev),
        .next(next)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Per channel: synchronised sample pipeline, debounced level, length of
    // the current disagreement run, and time since the press (dec/inc).
    int m_s1 [4];
    int m_s2 [4];
    int m_db [4];
    int m_run [4];
    int m_t [2];
    logic [3:0] exp_q[$];

    initial begin
        for (int i = 0; i < 4; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_run[i] = 0;
        end
        m_t[0] = -1;
        m_t[1] = -1;
    end

    always @(posedge clock) begin
        logic [3:0] raw;
        logic [3:0] cand;
        logic [3:0] e;
        bit flipped;
        raw  = {btn_next, btn_prev, btn_inc, btn_dec};
        cand = '0;
        e    = '0;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_run[i] = 0;
            end
            m_t[0] = -1;
            m_t[1] = -1;
        end else begin
            for (int ch = 0; ch < 4; ch++) begin
                flipped = 0;
                if (m_s2[ch] != m_db[ch]) begin
                    m_run[ch]++;
                    if (m_run[ch] == D) begin
                        flipped   = 1;
                        m_db[ch]  = m_s2[ch];
                        m_run[ch] = 0;
                        if (m_db[ch] == 1) begin
                            cand[ch] = 1'b1;
                            if (ch < 2) m_t[ch] = 0;
                        end else if (ch < 2) begin
                            m_t[ch] = -1;
                        end
                    end
                end else begin
                    m_run[ch] = 0;
                end
                if (ch < 2 && !flipped && m_t[ch] >= 0) begin
                    m_t[ch]++;
                    if (m_t[ch] >= H && ((m_t[ch] - H) % R) == 0) cand[ch] = 1'b1;
                end
                m_s2[ch] = m_s1[ch];
                m_s1[ch] = int'(raw[ch]);
            end
            e[0] = cand[0] & ~cand[1];
            e[1] = cand[1] & ~cand[0];
            e[2] = cand[2] & ~cand[3];
            e[3] = cand[3] & ~cand[2];
        end
        exp_q.push_back(e);
    end

    // ---------------- scoreboard ----------------
    int pulses [4];
    logic [3:0] last_got = '0;

    always @(negedge clock) begin
        logic [3:0] got;
        logic [3:0] e;
        got = {next, prev, inc, dec};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_dec",  32'(got[0]), 32'(e[0]));
            check("out_inc",  32'(got[1]), 32'(e[1]));
            check("out_prev", 32'(got[2]), 32'(e[2]));
            check("out_next", 32'(got[3]), 32'(e[3]));
            check("adjacent", 32'(got & last_got), 32'd0);
            check("opposing", 32'((got[0] & got[1]) | (got[2] & got[3])), 32'd0);
        end
        for (int i = 0; i < 4; i++) if (got[i]) pulses[i]++;
        last_got = got;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) pulses[i] = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        btn_dec = 1'b0; btn_inc = 1'b0; btn_prev = 1'b0; btn_next = 1'b0;
        clear_counts();
        wait_cycles(5);
        reset = 1'b0;
        check("reset_outs", 32'({next, prev, inc, dec}), 32'd0);
        check("reset_db_state", 32'(dut.state), 32'd0);
        check("reset_pulses", 32'(pulses[0] + pulses[1] + pulses[2] + pulses[3]), 32'd0);
        wait_cycles(5);

        // Bouncing next button, then a solid hold.
        clear_counts();
        for (int k = 0; k < 10; k++) begin
            btn_next = ~btn_next;
            wait_cycles(2);
        end
        btn_next = 1'b1;
        wait_cycles(30);
        btn_next = 1'b0;
        wait_cycles(15);
        check("bounce_next_count", 32'(pulses[3]), 32'd1);
        check("bounce_prev_count", 32'(pulses[2]), 32'd0);

        // Short glitch on prev.
        clear_counts();
        btn_prev = 1'b1;
        wait_cycles(3);
        btn_prev = 1'b0;
        wait_cycles(15);
        check("glitch_prev_count", 32'(pulses[2]), 32'd0);

        // Auto-repeat on inc: press, then repeats at +10 and every 3 after.
        clear_counts();
        btn_inc = 1'b1;
        wait_cycles(40);
        btn_inc = 1'b0;
        wait_cycles(15);
        check("repeat_inc_min", 32'(pulses[1] >= 5), 32'd1);
        check("repeat_dec_count", 32'(pulses[0]), 32'd0);

        // Conflict: both rise together, all pulses suppressed.
        clear_counts();
        btn_inc = 1'b1;
        btn_dec = 1'b1;
        wait_cycles(30);
        check("conflict_inc_count", 32'(pulses[1]), 32'd0);
        check("conflict_dec_count", 32'(pulses[0]), 32'd0);
        clear_counts();
        btn_dec = 1'b0;
        wait_cycles(30);
        check("conflict_inc_resumes", 32'(pulses[1] > 0), 32'd1);
        btn_inc = 1'b0;
        wait_cycles(15);

        // Reset while dec is auto-repeating.
        btn_dec = 1'b1;
        wait_cycles(25);
        reset = 1'b1;
        wait_cycles(1);
        check("midreset_dec", 32'(dec), 32'd0);
        reset = 1'b0;
        wait_cycles(30);
        btn_dec = 1'b0;
        wait_cycles(15);

        // Random button activity with occasional resets.
        for (int k = 0; k < 200; k++) begin
            btn_dec  = 1'($urandom_range(0, 1));
            btn_inc  = 1'($urandom_range(0, 1));
            btn_prev = 1'($urandom_range(0, 1));
            btn_next = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 24) == 0) begin
                reset = 1'b1;
                wait_cycles(1);
                reset = 1'b0;
            end
            wait_cycles($urandom_range(1, 25));
        end
        btn_dec = 1'b0; btn_inc = 1'b0; btn_prev = 1'b0; btn_next = 1'b0;
        wait_cycles(20);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
